// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared pipeline definitions for the MEM/WB boundary: occupancy states and control bit positions.
package mem_wb_skid_reg_pkg;

  // Encoding doubles as the entry count driven on the occupancy port.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  localparam int WB_EN    = 0;
  localparam int MEM_R_EN = 1;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded register for one MEM/WB payload (control, ALU result, memory value, destination).
module pipe_payload_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [DATA_W-1:0] d_mem,
  input  logic [DEST_W-1:0] d_dest,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_alu,
  output logic [DATA_W-1:0] q_mem,
  output logic [DEST_W-1:0] q_dest
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl <= '0;
      q_alu  <= '0;
      q_mem  <= '0;
      q_dest <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_alu  <= d_alu;
      q_mem  <= d_mem;
      q_dest <= d_dest;
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with optional two-entry skid buffer so upstream ready can be registered.
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic [1:0]        occupancy
);

  import mem_wb_skid_reg_pkg::*;

  skid_state_t state, state_next;
  logic        ready_q;
  logic        in_xfer, out_xfer;
  logic        main_load, main_from_skid, skid_load;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_alu, skid_alu, main_d_alu;
  logic [DATA_W-1:0] main_mem, skid_mem, main_d_mem;
  logic [DEST_W-1:0] main_dest, skid_dest, main_d_dest;

  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // ready_q is low through reset and the cycle after; with SKID=0 it only gates that window.
  if (SKID != 0) begin : g_rdy_reg
    assign in_ready = ready_q;
  end else begin : g_rdy_comb
    assign in_ready = ready_q && (!out_valid || out_ready);
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_next = ST_ONE;
            main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer && (SKID != 0)) begin
            state_next = ST_TWO;
            skid_load  = 1'b1;
          end else if (out_xfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_next     = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != ST_TWO);
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_alu  = main_from_skid ? skid_alu  : in_alu;
  assign main_d_mem  = main_from_skid ? skid_mem  : in_mem;
  assign main_d_dest = main_from_skid ? skid_dest : in_dest;

  pipe_payload_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .d_ctrl (main_d_ctrl),
    .d_alu  (main_d_alu),
    .d_mem  (main_d_mem),
    .d_dest (main_d_dest),
    .q_ctrl (main_ctrl),
    .q_alu  (main_alu),
    .q_mem  (main_mem),
    .q_dest (main_dest)
  );

  if (SKID != 0) begin : g_skid
    pipe_payload_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .d_ctrl (in_ctrl),
      .d_alu  (in_alu),
      .d_mem  (in_mem),
      .d_dest (in_dest),
      .q_ctrl (skid_ctrl),
      .q_alu  (skid_alu),
      .q_mem  (skid_mem),
      .q_dest (skid_dest)
    );
  end else begin : g_no_skid
    assign skid_ctrl = '0;
    assign skid_alu  = '0;
    assign skid_mem  = '0;
    assign skid_dest = '0;
  end

  // Control is masked on empty slots so a stale WB_en never reaches the register file.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_alu   = main_alu;
  assign out_mem   = main_mem;
  assign out_dest  = main_dest;
  assign wb_value  = out_ctrl[MEM_R_EN] ? out_mem : out_alu;
  assign occupancy = state;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed self-checking bench for mem_wb_skid_reg, covering SKID=1 and SKID=0 builds.
module tb_mem_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  in_ctrl, out_ctrl, occupancy;
  logic [31:0] in_alu, in_mem, out_alu, out_mem, wb_value;
  logic [4:0]  in_dest, out_dest;

  logic        s0_in_valid, s0_in_ready, s0_flush, s0_out_valid, s0_out_ready;
  logic [1:0]  s0_in_ctrl, s0_out_ctrl, s0_occupancy;
  logic [31:0] s0_in_alu, s0_in_mem, s0_out_alu, s0_out_mem, s0_wb_value;
  logic [4:0]  s0_in_dest, s0_out_dest;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(5), .CTRL_W(2), .SKID(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_mem(in_mem), .in_dest(in_dest),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_alu(out_alu), .out_mem(out_mem), .out_dest(out_dest),
    .wb_value(wb_value), .occupancy(occupancy)
  );

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(5), .CTRL_W(2), .SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .in_ctrl(s0_in_ctrl), .in_alu(s0_in_alu), .in_mem(s0_in_mem), .in_dest(s0_in_dest),
    .flush(s0_flush),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .out_ctrl(s0_out_ctrl), .out_alu(s0_out_alu), .out_mem(s0_out_mem), .out_dest(s0_out_dest),
    .wb_value(s0_wb_value), .occupancy(s0_occupancy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [31:0] a,
                               input logic [31:0] m, input logic [4:0] d,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_alu    = a;
    in_mem    = m;
    in_dest   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 2'b11, 32'h5, 32'h6, 5'd7, 1'b1, 1'b0);
    s0_in_valid = 1'b1; s0_in_ctrl = 2'b11; s0_in_alu = 32'h1; s0_in_mem = 32'h2;
    s0_in_dest = 5'd3; s0_out_ready = 1'b1; s0_flush = 1'b0;

    // Reset: everything low, ready held off until the first edge after release.
    #3;
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_ctrl", {62'd0, out_ctrl}, 64'd0);
    checkOutput("rst_out_alu", {32'd0, out_alu}, 64'd0);
    checkOutput("rst_out_mem", {32'd0, out_mem}, 64'd0);
    checkOutput("rst_out_dest", {59'd0, out_dest}, 64'd0);
    checkOutput("rst_occupancy", {62'd0, occupancy}, 64'd0);
    checkOutput("rst_s0_in_ready", {63'd0, s0_in_ready}, 64'd0);
    #9;
    rst = 1'b0;
    s0_in_valid = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("rel_in_ready_low", {63'd0, in_ready}, 64'd0);
    cycle();
    checkOutput("rel_in_ready_high", {63'd0, in_ready}, 64'd1);
    checkOutput("rel_occupancy", {62'd0, occupancy}, 64'd0);

    // Streaming with one-cycle latency.
    applyStimulus(1'b1, 2'b01, 32'h10, 32'h0, 5'd1, 1'b1, 1'b0);
    cycle();
    checkOutput("stream_v0", {63'd0, out_valid}, 64'd1);
    checkOutput("stream_a0", {32'd0, out_alu}, 64'h10);
    checkOutput("stream_d0", {59'd0, out_dest}, 64'd1);
    applyStimulus(1'b1, 2'b01, 32'h11, 32'h0, 5'd2, 1'b1, 1'b0);
    cycle();
    checkOutput("stream_a1", {32'd0, out_alu}, 64'h11);
    applyStimulus(1'b1, 2'b01, 32'h12, 32'h0, 5'd3, 1'b1, 1'b0);
    cycle();
    checkOutput("stream_a2", {32'd0, out_alu}, 64'h12);
    checkOutput("stream_occ", {62'd0, occupancy}, 64'd1);
    applyStimulus(1'b0, 2'b01, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    cycle();
    checkOutput("stream_empty_v", {63'd0, out_valid}, 64'd0);
    checkOutput("stream_empty_ctrl", {62'd0, out_ctrl}, 64'd0);

    // Backpressure fills the skid entry; 0xC waits upstream.
    applyStimulus(1'b1, 2'b01, 32'hA, 32'h0, 5'd10, 1'b0, 1'b0);
    cycle();
    checkOutput("bp_occ1", {62'd0, occupancy}, 64'd1);
    checkOutput("bp_rdy1", {63'd0, in_ready}, 64'd1);
    applyStimulus(1'b1, 2'b01, 32'hB, 32'h0, 5'd11, 1'b0, 1'b0);
    cycle();
    checkOutput("bp_occ2", {62'd0, occupancy}, 64'd2);
    checkOutput("bp_rdy2", {63'd0, in_ready}, 64'd0);
    applyStimulus(1'b1, 2'b01, 32'hC, 32'h0, 5'd12, 1'b0, 1'b0);
    cycle();
    checkOutput("bp_hold_occ", {62'd0, occupancy}, 64'd2);
    checkOutput("bp_hold_head", {32'd0, out_alu}, 64'hA);
    applyStimulus(1'b1, 2'b01, 32'hC, 32'h0, 5'd12, 1'b1, 1'b0);
    cycle();
    checkOutput("bp_drain_b", {32'd0, out_alu}, 64'hB);
    checkOutput("bp_drain_dest_b", {59'd0, out_dest}, 64'd11);
    checkOutput("bp_drain_occ", {62'd0, occupancy}, 64'd1);
    checkOutput("bp_drain_rdy", {63'd0, in_ready}, 64'd1);
    cycle();
    checkOutput("bp_drain_c", {32'd0, out_alu}, 64'hC);
    checkOutput("bp_drain_occ_c", {62'd0, occupancy}, 64'd1);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    cycle();
    checkOutput("bp_done", {62'd0, occupancy}, 64'd0);

    // Flush while full, then flush overriding an accepted input.
    applyStimulus(1'b1, 2'b01, 32'h20, 32'h0, 5'd4, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 2'b01, 32'h21, 32'h0, 5'd5, 1'b0, 1'b0);
    cycle();
    checkOutput("fl_pre_occ", {62'd0, occupancy}, 64'd2);
    applyStimulus(1'b1, 2'b01, 32'h22, 32'h0, 5'd6, 1'b0, 1'b1);
    cycle();
    checkOutput("fl_two_v", {63'd0, out_valid}, 64'd0);
    checkOutput("fl_two_occ", {62'd0, occupancy}, 64'd0);
    checkOutput("fl_two_ctrl", {62'd0, out_ctrl}, 64'd0);
    applyStimulus(1'b1, 2'b01, 32'h30, 32'h0, 5'd6, 1'b0, 1'b0);
    cycle();
    checkOutput("fl_one_occ", {62'd0, occupancy}, 64'd1);
    applyStimulus(1'b1, 2'b01, 32'h31, 32'h0, 5'd7, 1'b0, 1'b1);
    checkOutput("fl_one_rdy", {63'd0, in_ready}, 64'd1);
    cycle();
    checkOutput("fl_one_occ0", {62'd0, occupancy}, 64'd0);
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    cycle();
    checkOutput("fl_discarded", {63'd0, out_valid}, 64'd0);

    // Write-back value selection.
    applyStimulus(1'b1, 2'b11, 32'h4, 32'hDEAD_BEEF, 5'd8, 1'b0, 1'b0);
    cycle();
    checkOutput("mux_mem", {32'd0, wb_value}, 64'hDEAD_BEEF);
    checkOutput("mux_ctrl11", {62'd0, out_ctrl}, 64'd3);
    applyStimulus(1'b1, 2'b01, 32'h4, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0);
    cycle();
    checkOutput("mux_alu", {32'd0, wb_value}, 64'h4);
    checkOutput("mux_ctrl01", {62'd0, out_ctrl}, 64'd1);

    // Asynchronous reset while two entries are held.
    applyStimulus(1'b1, 2'b01, 32'h50, 32'h0, 5'd1, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checkOutput("mid_pre_occ", {62'd0, occupancy}, 64'd2);
    rst = 1'b1;
    #2;
    checkOutput("mid_occ", {62'd0, occupancy}, 64'd0);
    checkOutput("mid_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_alu", {32'd0, out_alu}, 64'd0);
    checkOutput("mid_rdy", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    cycle();
    checkOutput("mid_rdy_after", {63'd0, in_ready}, 64'd1);
    checkOutput("mid_occ_after", {62'd0, occupancy}, 64'd0);

    // SKID=0: ready tracks out_ready combinationally while the register is full.
    s0_in_valid = 1'b1; s0_in_ctrl = 2'b01; s0_in_alu = 32'h40; s0_out_ready = 1'b0;
    #1;
    checkOutput("s0_rdy_empty", {63'd0, s0_in_ready}, 64'd1);
    cycle();
    checkOutput("s0_valid", {63'd0, s0_out_valid}, 64'd1);
    checkOutput("s0_alu40", {32'd0, s0_out_alu}, 64'h40);
    checkOutput("s0_rdy_full", {63'd0, s0_in_ready}, 64'd0);
    checkOutput("s0_occ", {62'd0, s0_occupancy}, 64'd1);
    s0_out_ready = 1'b1; s0_in_alu = 32'h41;
    #1;
    checkOutput("s0_rdy_follow", {63'd0, s0_in_ready}, 64'd1);
    cycle();
    checkOutput("s0_alu41", {32'd0, s0_out_alu}, 64'h41);
    s0_out_ready = 1'b0;
    #1;
    checkOutput("s0_rdy_drop", {63'd0, s0_in_ready}, 64'd0);
    s0_in_valid = 1'b0;
    cycle();
    checkOutput("s0_hold", {32'd0, s0_out_alu}, 64'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
